dma_line_ctrl: RTL and testbench

- Parametrised successor to the single-burst DMA engine.
- Moves a command-specified number of words from an external device to memory, one cache line per bus write.
- Uses a BR/BG bus handshake with the CPU and reports completion with a one-cycle interrupt pulse.
- Sits beside the CPU on the shared memory bus. addr, data and READ are tri-stated except while this block is writing.

---
 rtl/dma_line_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_dma_line_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dma_line_ctrl
//  Description : Line-oriented DMA engine. Accepts a {length, base} command,
//                requests the shared memory bus with a BR/BG handshake, and
//                writes the requested words from an external device to memory
//                one cache line per bus write. Completion is reported with a
//                one-cycle interrupt pulse, with err flagging an aborted job.
//
//  Ports       : CLK, RST (sync, active-high)
//                BG         - bus grant from CPU
//                cmd_valid  - one-cycle command strobe
//                cmd        - {length, base address}
//                edata      - line presented by the device at 'offset'
//                BR         - bus request
//                READ       - memory-write strobe (1 while writing, else z)
//                addr, data - memory line address / line data (z when idle)
//                offset     - line index requested from the device
//                busy       - high from command accept through interrupt
//                interrupt  - one-cycle completion pulse
//                err        - valid with interrupt, 1 = aborted
//
//  Build option: DMA_PREEMPT_EN - when defined, losing BG mid-transfer pauses
//                and resumes the job; when undefined the job aborts with err.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_line_ctrl #(
    parameter int WORD_SIZE    = 16,
    parameter int LINE_WORDS   = 4,
    parameter int ADDR_BITS    = 12,
    parameter int LEN_BITS     = 4,
    parameter int OFF_BITS     = 2,
    parameter int WRITE_CYCLES = 5
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             BG,
    input  logic                             cmd_valid,
    input  logic [WORD_SIZE-1:0]             cmd,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  edata,
    output logic                             BR,
    output logic                             READ,
    output logic [WORD_SIZE-1:0]             addr,
    output logic [LINE_WORDS*WORD_SIZE-1:0]  data,
    output logic [OFF_BITS-1:0]              offset,
    output logic                             busy,
    output logic                             interrupt,
    output logic                             err
);

    localparam int c_LW_LOG2 = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
    // Line counter must hold 'lines' itself, which can exceed the offset width.
    localparam int c_CNT_W   = LEN_BITS + 1;
    localparam int c_SUM_W   = LEN_BITS + c_LW_LOG2 + 1;
    localparam int c_WC_W    = $clog2(WRITE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SETUP   = 3'd2,
        S_WRITE   = 3'd3,
        S_RELEASE = 3'd4,
        S_IRQ     = 3'd5,
        S_PAUSE   = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_BITS-1:0]  r_base;
    logic [c_CNT_W-1:0]    r_lines;
    logic [c_CNT_W-1:0]    r_n;
    logic [c_WC_W-1:0]     r_wcnt;
    logic                  r_err;
`ifdef DMA_PREEMPT_EN
    logic                  r_preempt;
`endif

    logic [LEN_BITS-1:0]   w_len;
    logic [c_SUM_W-1:0]    w_len_sum;
    logic [c_CNT_W-1:0]    w_lines;
    logic [c_CNT_W-1:0]    w_n_inc;
    logic                  w_more;
    logic                  w_last_cyc;
    logic [ADDR_BITS-1:0]  w_line_addr;
    logic                  w_br;
    logic                  w_wr;
    logic                  w_busy;
    logic                  w_irq;
    logic                  w_err;

    // Command decode: lines = ceil(len / LINE_WORDS)
    assign w_len      = cmd[ADDR_BITS+LEN_BITS-1:ADDR_BITS];
    assign w_len_sum  = c_SUM_W'(w_len) + c_SUM_W'(LINE_WORDS - 1);
    assign w_lines    = c_CNT_W'(w_len_sum >> c_LW_LOG2);

    assign w_n_inc    = r_n + 1'b1;
    assign w_more     = (w_n_inc < r_lines);
    assign w_last_cyc = (r_wcnt == c_WC_W'(WRITE_CYCLES - 1));

    // Line address wraps silently inside the ADDR_BITS window.
    assign w_line_addr = r_base + (ADDR_BITS'(r_n) << c_LW_LOG2);

    generate
        if (WORD_SIZE > ADDR_BITS + LEN_BITS) begin : g_unused_cmd
            logic w_unused_cmd_bits;
            assign w_unused_cmd_bits = ^cmd[WORD_SIZE-1:ADDR_BITS+LEN_BITS];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_br        = 1'b0;
        w_wr        = 1'b0;
        w_busy      = (r_state != S_IDLE);
        w_irq       = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = (w_len == '0) ? S_IRQ : S_REQ;
                end
            end
            S_REQ: begin
                w_br = 1'b1;
                if (BG) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_br = 1'b1;
`ifdef DMA_PREEMPT_EN
                // The line is committed once SETUP is entered; a lost grant
                // is only acted upon after the line finishes.
                w_state_nxt = S_WRITE;
`else
                w_state_nxt = BG ? S_WRITE : S_IRQ;
`endif
            end
            S_WRITE: begin
                w_br = 1'b1;
                w_wr = 1'b1;
`ifdef DMA_PREEMPT_EN
                if (w_last_cyc) begin
                    if (!w_more) begin
                        w_state_nxt = S_RELEASE;
                    end else if (r_preempt || !BG) begin
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end
`else
                if (!BG) begin
                    w_state_nxt = S_IRQ;
                end else if (w_last_cyc) begin
                    w_state_nxt = w_more ? S_SETUP : S_RELEASE;
                end
`endif
            end
            S_RELEASE: begin
                if (!BG) begin
                    w_state_nxt = S_IRQ;
                end
            end
            S_PAUSE: begin
                w_state_nxt = S_REQ;
            end
            S_IRQ: begin
                w_irq       = 1'b1;
                w_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_lines <= '0;
            r_n     <= '0;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
`ifdef DMA_PREEMPT_EN
            r_preempt <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && cmd_valid) begin
                r_base  <= cmd[ADDR_BITS-1:0];
                r_lines <= w_lines;
                r_n     <= '0;
                r_err   <= 1'b0;
            end

            if (r_state == S_WRITE) begin
                if (w_last_cyc) begin
                    r_wcnt <= '0;
                    r_n    <= w_n_inc;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end else begin
                r_wcnt <= '0;
            end

`ifdef DMA_PREEMPT_EN
            if ((r_state == S_SETUP || r_state == S_WRITE) && !BG) begin
                r_preempt <= 1'b1;
            end else if (r_state == S_PAUSE) begin
                r_preempt <= 1'b0;
            end
`else
            if ((r_state == S_SETUP || r_state == S_WRITE) && !BG) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Bus-facing outputs: driven only while this block owns a write.
    // ------------------------------------------------------------------
    assign BR        = w_br;
    assign READ      = w_wr ? 1'b1 : 1'bz;
    assign addr      = w_wr ? WORD_SIZE'(w_line_addr) : {WORD_SIZE{1'bz}};
    assign data      = w_wr ? edata : {(LINE_WORDS*WORD_SIZE){1'bz}};
    assign offset    = OFF_BITS'(r_n);
    assign busy      = w_busy;
    assign interrupt = w_irq;
    assign err       = w_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_line_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dma_line_ctrl
//  Description : Directed self-checking bench for dma_line_ctrl. A small
//                bus-arbiter model grants BG two cycles after BR and drops it
//                one cycle after BR falls; every write burst is logged and
//                compared with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_line_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        BG;
    logic        cmd_valid;
    logic [15:0] cmd;
    wire         BR;
    wire         READ;
    wire  [15:0] addr;
    wire  [63:0] data;
    wire  [1:0]  offset;
    wire         busy;
    wire         interrupt;
    wire         err;

    // Device model: each line carries its own index so the data path is visible.
    wire  [63:0] edata = {4{16'hA500 + 16'(offset)}};

    dma_line_ctrl #(
        .WORD_SIZE    (16),
        .LINE_WORDS   (4),
        .ADDR_BITS    (12),
        .LEN_BITS     (4),
        .OFF_BITS     (2),
        .WRITE_CYCLES (5)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .BG        (BG),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .edata     (edata),
        .BR        (BR),
        .READ      (READ),
        .addr      (addr),
        .data      (data),
        .offset    (offset),
        .busy      (busy),
        .interrupt (interrupt),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Per-run log
    logic [15:0] q_addr[$];
    int          q_off[$];
    int          q_len[$];
    int          q_start[$];
    logic [63:0] q_data[$];
    int          irq_cnt;
    int          irq_cyc;
    int          br_first;
    int          br_rises;
    logic        irq_err;
    logic        irq_br;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command and run it to completion (bounded by max_cyc).
    // drop_line >= 0 withdraws BG two cycles into that write burst and holds
    // it low until BR is released.
    task automatic run(input logic [15:0] c, input int drop_line, input int max_cyc);
        int brc     = 0;
        int run_len = 0;
        bit in_wr   = 0;
        bit hold    = 0;
        bit dropped = 0;
        bit br_prev = 0;
        q_addr.delete(); q_off.delete(); q_len.delete(); q_start.delete(); q_data.delete();
        irq_cnt = 0; irq_cyc = -1; br_first = -1; br_rises = 0; irq_err = 1'b0; irq_br = 1'b0;
        cmd       = c;
        cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            tick();
            cmd_valid = 1'b0;
            if (READ === 1'b1) begin
                if (!in_wr) begin
                    q_addr.push_back(addr);
                    q_off.push_back(int'(offset));
                    q_data.push_back(data);
                    q_start.push_back(cyc);
                    in_wr   = 1;
                    run_len = 0;
                end
                run_len++;
            end else if (in_wr) begin
                q_len.push_back(run_len);
                in_wr = 0;
            end
            if (BR === 1'b1 && !br_prev) begin
                br_rises++;
                if (br_first < 0) br_first = cyc;
            end
            br_prev = (BR === 1'b1);
            if (interrupt === 1'b1) begin
                irq_cnt++;
                irq_err = err;
                irq_br  = BR;
                if (irq_cyc < 0) irq_cyc = cyc;
            end
            if (hold) begin
                BG = 1'b0;
                if (BR !== 1'b1) begin
                    hold = 0;
                    brc  = 0;
                end
            end else if (BR === 1'b1) begin
                brc++;
                if (brc >= 2) BG = 1'b1;
            end else begin
                brc = 0;
                BG  = 1'b0;
            end
            if (drop_line >= 0 && !dropped && in_wr && q_addr.size() == drop_line + 1 && run_len == 2) begin
                BG      = 1'b0;
                hold    = 1;
                dropped = 1;
            end
            if (irq_cyc >= 0 && cyc >= irq_cyc + 3) break;
        end
    endtask

    initial begin
        logic [63:0] exp_d0;
        int          quiet_irq;
        exp_d0    = {4{16'hA500}};
        RST       = 1'b1;
        BG        = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 16'h0000;
        tick();
        tick();

        // ---- Reset state ----
        chk("rst_BR",        BR,              1'b0);
        chk("rst_READ_off",  (READ !== 1'b1), 1'b1);
        chk("rst_busy",      busy,            1'b0);
        chk("rst_interrupt", interrupt,       1'b0);
        chk("rst_err",       err,             1'b0);
        chk("rst_offset",    offset,          2'd0);
        RST = 1'b0;
        tick();

        // ---- Basic: 12 words from 0x1F4 -> 3 lines ----
        run(16'hC1F4, -1, 60);
        chk("basic_br_first", br_first,    1);
        chk("basic_nlines",   q_addr.size(), 3);
        chk("basic_addr0",    q_addr[0],   16'h01F4);
        chk("basic_addr1",    q_addr[1],   16'h01F8);
        chk("basic_addr2",    q_addr[2],   16'h01FC);
        chk("basic_off0",     q_off[0],    0);
        chk("basic_off1",     q_off[1],    1);
        chk("basic_off2",     q_off[2],    2);
        chk("basic_len0",     q_len[0],    5);
        chk("basic_len1",     q_len[1],    5);
        chk("basic_len2",     q_len[2],    5);
        chk("basic_data0",    q_data[0],   exp_d0);
        chk("basic_start0",   q_start[0],  4);
        chk("basic_spacing",  q_start[1] - q_start[0], 6);
        chk("basic_irq_cnt",  irq_cnt,     1);
        chk("basic_irq_br",   irq_br,      1'b0);
        chk("basic_err",      irq_err,     1'b0);
        chk("basic_idle_busy", busy,       1'b0);

        // ---- Partial line: 5 words -> 2 lines ----
        run(16'h5100, -1, 60);
        chk("part_nlines", q_addr.size(), 2);
        chk("part_addr0",  q_addr[0],     16'h0100);
        chk("part_addr1",  q_addr[1],     16'h0104);
        chk("part_irq",    irq_cnt,       1);

        // ---- Zero length ----
        run(16'h0123, -1, 10);
        chk("zero_br_rises", br_rises,      0);
        chk("zero_writes",   q_addr.size(), 0);
        chk("zero_irq_cnt",  irq_cnt,       1);
        chk("zero_irq_lat",  (irq_cyc >= 1 && irq_cyc <= 2), 1'b1);
        chk("zero_err",      irq_err,       1'b0);

        // ---- Address wrap ----
        run(16'h8FFC, -1, 60);
        chk("wrap_nlines", q_addr.size(), 2);
        chk("wrap_addr0",  q_addr[0],     16'h0FFC);
        chk("wrap_addr1",  q_addr[1],     16'h0000);

        // ---- Busy ignore and mid-write reset ----
        cmd       = 16'hC1F4;
        cmd_valid = 1'b1;
        BG        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cmd_valid = 1'b0;
            if (BR === 1'b1) BG = 1'b1;
            if (READ === 1'b1) break;
        end
        chk("busy_in_write", READ, 1'b1);
        cmd       = 16'h0123;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("busy_ignore_busy", busy, 1'b1);
        chk("busy_ignore_read", READ, 1'b1);
        chk("busy_ignore_addr", addr, 16'h01F4);
        RST = 1'b1;
        tick();
        chk("midrst_BR",   BR,              1'b0);
        chk("midrst_READ", (READ !== 1'b1), 1'b1);
        chk("midrst_busy", busy,            1'b0);
        chk("midrst_irq",  interrupt,       1'b0);
        RST       = 1'b0;
        BG        = 1'b0;
        quiet_irq = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (interrupt === 1'b1) quiet_irq++;
        end
        chk("midrst_no_irq", quiet_irq, 0);
        run(16'h5100, -1, 60);
        chk("after_rst_nlines", q_addr.size(), 2);
        chk("after_rst_addr0",  q_addr[0],     16'h0100);
        chk("after_rst_irq",    irq_cnt,       1);

        // ---- Grant withdrawn during the first line ----
        run(16'hC1F4, 0, 120);
`ifdef DMA_PREEMPT_EN
        chk("pre_nlines",   q_addr.size(), 3);
        chk("pre_addr0",    q_addr[0],     16'h01F4);
        chk("pre_addr1",    q_addr[1],     16'h01F8);
        chk("pre_addr2",    q_addr[2],     16'h01FC);
        chk("pre_len0",     q_len[0],      5);
        chk("pre_br_rises", br_rises,      2);
        chk("pre_irq",      irq_cnt,       1);
        chk("pre_err",      irq_err,       1'b0);
`else
        chk("abort_nlines", q_addr.size(), 1);
        chk("abort_addr0",  q_addr[0],     16'h01F4);
        chk("abort_len0",   (q_len[0] < 5), 1'b1);
        chk("abort_irq",    irq_cnt,       1);
        chk("abort_err",    irq_err,       1'b1);
        chk("abort_br",     irq_br,        1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
